// File: rtl/s641_tb_pkg.sv
// Shared types and default constants for the s641 response MISR.
package s641_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          DEF_WIDTH = 24;
  localparam int          DEF_CNT_W = 16;
  localparam logic [23:0] DEF_POLY  = 24'hE10000;
  localparam logic [23:0] DEF_SEED  = 24'hFFFFFF;

endpackage

// File: rtl/s641_misr_core.sv
// Galois MISR step and signature register with seed-load and enable controls.
module s641_misr_core #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_sig,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ i_din;
  end

  // Seed load takes priority so a restart never folds in a stray sample.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig  = r_sig;
  assign o_next = w_next;

endmodule

// File: rtl/s641_resp_misr.sv
// Response-compaction MISR with run control; optional golden compare under SIG_COMPARE_EN.
module s641_resp_misr
  import s641_tb_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               CNT_W = DEF_CNT_W,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_in,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] count,
  output logic             pass
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_len;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sig;
  logic [WIDTH-1:0] w_sig_next;

  assign w_start_ok = start && (r_state != ST_RUN);
  assign w_accept   = resp_valid && (r_state == ST_RUN);
  // count < r_len holds throughout RUN, so the increment can neither pass len nor wrap.
  assign w_last     = w_accept && ((r_count + CNT_W'(1)) == r_len);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_count <= '0;
      r_len   <= '0;
    end else if (w_start_ok) begin
      r_count <= '0;
      r_len   <= len;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  s641_misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .CK     (CK),
    .RN     (RN),
    .i_load (w_start_ok),
    .i_en   (w_accept),
    .i_din  (resp_in),
    .o_sig  (w_sig),
    .o_next (w_sig_next)
  );

`ifdef SIG_COMPARE_EN
  logic [WIDTH-1:0] r_golden;
  logic             r_pass;

  // A zero-length run enters DONE holding SEED, so that is what gets compared.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_golden <= '0;
      r_pass   <= 1'b0;
    end else if (w_start_ok) begin
      r_golden <= golden;
      r_pass   <= (len == '0) && (SEED == golden);
    end else if (w_last) begin
      r_pass   <= (w_sig_next == r_golden);
    end
  end

  assign pass = r_pass;
`else
  logic w_unused;
  assign w_unused = ^{golden, w_sig_next};
  assign pass     = 1'b0;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = w_sig;
  assign count     = r_count;

endmodule

// File: tb/tb_s641_resp_misr.sv
// Directed self-checking bench for s641_resp_misr with hand-computed signatures.
module tb_s641_resp_misr;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        resp_valid = 1'b0;
  logic [23:0] resp_in = '0;
  logic [23:0] golden = '0;
  logic        busy;
  logic        done;
  logic [23:0] signature;
  logic [15:0] count;
  logic        pass;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

`ifdef SIG_COMPARE_EN
  localparam logic EXP_PASS_MATCH = 1'b1;
`else
  localparam logic EXP_PASS_MATCH = 1'b0;
`endif

  always #5 CK = ~CK;

  s641_resp_misr u_dut (
    .CK         (CK),
    .RN         (RN),
    .start      (start),
    .len        (len),
    .resp_valid (resp_valid),
    .resp_in    (resp_in),
    .golden     (golden),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .count      (count),
    .pass       (pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CK);
  endtask

  task automatic do_start(input logic [15:0] l, input logic [23:0] g);
    start  = 1'b1;
    len    = l;
    golden = g;
    step();
    start  = 1'b0;
  endtask

  // Accepted samples carry 1,2,3,4; gap cycles carry junk that must be ignored.
  logic        pat_v  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [23:0] pat_d  [6] = '{24'h000001, 24'hABCDEF, 24'h000002, 24'h000003, 24'h5A5A5A, 24'h000004};
  logic [15:0] pat_c  [6] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd4};
  logic [23:0] pat_s  [6] = '{24'h1EFFFF, 24'h1EFFFF, 24'h3DFFFC, 24'h7BFFFB, 24'h7BFFFB, 24'hF7FFF2};

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cnt", count, 0);
    chk("rst_pass", pass, 0);
    RN = 1'b1;
    step();

    // Reset mid-run with count=3
    do_start(16'd5, 24'h0);
    resp_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      resp_in = 24'(i);
      step();
    end
    resp_valid = 1'b0;
    chk("mid_cnt", count, 3);
    chk("mid_busy", busy, 1);
    #2 RN = 1'b0;
    #1;
    chk("arst_sig", signature, 0);
    chk("arst_cnt", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    step();
    RN = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);

    // Single sample, matching golden
    do_start(16'd1, 24'h1EFFFF);
    chk("s1_busy0", busy, 1);
    chk("s1_sig0", signature, 24'hFFFFFF);
    chk("s1_cnt0", count, 0);
    resp_valid = 1'b1;
    resp_in    = 24'h000001;
    step();
    resp_valid = 1'b0;
    chk("s1_sig", signature, 24'h1EFFFF);
    chk("s1_cnt", count, 1);
    chk("s1_done", done, 1);
    chk("s1_busy", busy, 0);
    chk("s1_pass", pass, EXP_PASS_MATCH);

    // resp_valid in DONE is ignored
    resp_valid = 1'b1;
    resp_in    = 24'h123456;
    step();
    resp_valid = 1'b0;
    chk("done_hold_sig", signature, 24'h1EFFFF);
    chk("done_hold_cnt", count, 1);
    chk("done_hold_done", done, 1);

    // Single sample, mismatching golden
    do_start(16'd1, 24'h000000);
    chk("s1b_pass_clr", pass, 0);
    resp_valid = 1'b1;
    resp_in    = 24'h000001;
    step();
    resp_valid = 1'b0;
    chk("s1b_sig", signature, 24'h1EFFFF);
    chk("s1b_pass", pass, 0);

    // Zero length
    do_start(16'd0, 24'h0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_sig", signature, 24'hFFFFFF);
    chk("z_cnt", count, 0);
    step();
    chk("z_busy2", busy, 0);

    // Gapped stream, len=4
    do_start(16'd4, 24'h0);
    for (int i = 0; i < 6; i++) begin
      resp_valid = pat_v[i];
      resp_in    = pat_d[i];
      step();
      chk($sformatf("gap_cnt%0d", i), count, pat_c[i]);
      chk($sformatf("gap_sig%0d", i), signature, pat_s[i]);
      chk($sformatf("gap_done%0d", i), done, (i == 5) ? 1 : 0);
    end
    resp_valid = 1'b0;

    // Ignored start mid-run
    do_start(16'd4, 24'h0);
    resp_valid = 1'b1;
    resp_in    = 24'h000001;
    step();
    resp_in = 24'h000002;
    start   = 1'b1;
    len     = 16'd9;
    step();
    start   = 1'b0;
    chk("ign_busy", busy, 1);
    chk("ign_cnt", count, 2);
    resp_in = 24'h000003;
    step();
    resp_in = 24'h000004;
    step();
    resp_valid = 1'b0;
    chk("ign_cnt_end", count, 4);
    chk("ign_sig_end", signature, 24'hF7FFF2);
    chk("ign_done", done, 1);
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    chk("ign_cnt_cap", count, 4);

    // Restart from DONE
    do_start(16'd4, 24'h0);
    chk("rs_sig", signature, 24'hFFFFFF);
    chk("rs_cnt", count, 0);
    chk("rs_busy", busy, 1);
    chk("rs_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
